// File: rtl/sysid_check_master_pkg.sv
// rtl/sysid_check_master_pkg.sv - shared state encoding, word addresses and counter widths
package sysid_check_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_GAP   = 3'd3,
        ST_CMP   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int WAIT_W  = 16;
    localparam int RETRY_W = 4;

endpackage

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads sysid ID/timestamp words over Avalon-MM and checks them
module sysid_check_master
    import sysid_check_master_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h11223344,
    parameter logic [31:0] EXPECTED_TS    = 32'h56FA7A44,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_MAX      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [WAIT_W-1:0]  TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(RETRY_MAX);

    state_t              state_q, state_d;
    logic                word_q, word_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                read_q, read_d;
    logic                addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                id_ok_q, id_ok_d;
    logic                ts_ok_q, ts_ok_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         id_value_q, id_value_d;
    logic [31:0]         ts_value_q, ts_value_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= ADDR_ID;
            wait_q     <= '0;
            retry_q    <= '0;
            read_q     <= 1'b0;
            addr_q     <= ADDR_ID;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wait_q     <= wait_d;
            retry_q    <= retry_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        wait_d     = wait_q;
        retry_d    = retry_q;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    retry_d   = '0;
                    wait_d    = '0;
                    word_d    = ADDR_ID;
                    state_d   = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    wait_d = '0;
                    if (state_q == ST_RD_ID) begin
                        id_value_d = avm_readdata;
                        retry_d    = '0;
                        word_d     = ADDR_TS;
                        state_d    = ST_RD_TS;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = ST_CMP;
                    end
                end else if (wait_q == TIMEOUT_LIM) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        wait_d  = '0;
                        state_d = ST_GAP;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = ST_FIN;
                    end
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = (word_q == ADDR_TS) ? ST_RD_TS : ST_RD_ID;
            end
            ST_CMP: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TS);
                pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
                state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus strobes are registered off the next state so they line up with it.
        read_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
        if (state_d == ST_RD_TS) begin
            addr_d = ADDR_TS;
        end else if (state_d == ST_RD_ID) begin
            addr_d = ADDR_ID;
        end else begin
            addr_d = addr_q;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d = (state_d == ST_FIN);
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: doc/sysid_check_master.md
# sysid_check_master

Avalon-MM master that sequences reads of the system-ID slave (word 0 = ID, word 1 = timestamp) and verifies both against build-time expected values. Sits beside the sysid slave on the control interconnect. Gives boot/reset logic a hardware pass/fail verdict before the video pipeline is released. Bounded per-read timeout with limited retries, so a hung slave cannot stall bring-up.

## Interface
Parameters:
- EXPECTED_ID, 32'h11223344 (287454020): value required at word 0.
- EXPECTED_TS, 32'h56FA7A44 (1459255876): value required at word 1.
- TIMEOUT_CYCLES, 255: maximum wait-stalled cycles per read attempt; range 1..65535.
- RETRY_MAX, 3: number of re-attempts after the first timed-out read of a word; range 0..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle check request; honoured only in IDLE.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  Avalon read strobe.
- avm_readdata  in  32  slave read data, fixed latency 0.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  ID and timestamp both matched; held until next accepted start.
- id_ok  out  1  ID matched; held like pass.
- ts_ok  out  1  timestamp matched; held like pass.
- timeout  out  1  retries exhausted; held like pass.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

## Operation
- States: IDLE, RD_ID, RD_TS, GAP, CMP, FIN.
- IDLE:
  - On start=1, clear pass, id_ok, ts_ok, timeout, the retry count and the wait counter.
  - Go to RD_ID.
- RD_ID:
  - Drive avm_read=1 and avm_address=0.
  - If avm_waitrequest=0, capture avm_readdata into id_value, clear the counters and go to RD_TS.
  - Otherwise increment the wait counter.
- RD_TS: same as RD_ID, with avm_address=1 and capture into ts_value. On acceptance, go to CMP.
- Timeout:
  - Condition: the wait counter equals TIMEOUT_CYCLES while still stalled.
  - If retry count < RETRY_MAX, increment the retry count, clear the wait counter and go to GAP.
  - Otherwise set timeout=1 and go to FIN.
- GAP:
  - Drive avm_read=0 for exactly one cycle.
  - Then return to the state that timed out; a register holds the word index.
- CMP:
  - id_ok := (id_value == EXPECTED_ID).
  - ts_ok := (ts_value == EXPECTED_TS).
  - pass := id_ok & ts_ok.
  - Go to FIN.
- FIN: done=1 for one cycle, then go to IDLE.
- Retry count is per word: it is cleared when the ID word is accepted.
- Width rules:
  - Wait counter is 16 bits and saturates.
  - Retry count is 4 bits.
  - Comparisons are full 32-bit equality.
- start is ignored while busy. Simultaneous start and done: start is ignored, because the FSM is still in FIN that cycle.
- After a timeout abort, the ID/TS values are not compared: id_ok, ts_ok and pass stay 0. id_value keeps its last capture.
- Reset mid-transaction:
  - avm_read drops immediately (asynchronous).
  - No done pulse is generated.
  - All outputs return to their reset values.

## Timing
- Reset values:
  - State IDLE.
  - avm_read=0, avm_address=0.
  - busy=0, done=0.
  - pass=0, id_ok=0, ts_ok=0, timeout=0.
  - id_value=0, ts_value=0.
- All outputs are registered; none depend combinationally on inputs.
- Avalon rules:
  - avm_address is stable whenever avm_read=1.
  - A transfer completes on a clock edge with avm_read=1 and avm_waitrequest=0.
- Latency with zero wait states, start sampled at edge 0:
  - avm_read high after edges 1–2.
  - CMP after edge 3; done and results valid after edge 4.
  - busy high after edges 1–3, low together with done.
- Each stalled cycle adds one cycle of latency.
- Each timeout adds TIMEOUT_CYCLES+1 wait cycles plus one GAP cycle.

## Structure
- The shared package holds:
  - the state enum;
  - the address constants ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - the counter widths.
- Single module with no sub-modules.
- The wait counter is small enough to stay inline.

## Test plan
- Zero-wait slave returns 32'h11223344 / 32'h56FA7A44: done 4 cycles after start; pass=1, id_ok=1, ts_ok=1, timeout=0.
- Slave returns ID 32'h11223345: pass=0, id_ok=0, ts_ok=1; id_value=32'h11223345.
- waitrequest held for 3 cycles on each word: done 10 cycles after start, pass=1; avm_address stable throughout each stall.
- TIMEOUT_CYCLES=4, RETRY_MAX=1, waitrequest stuck high on word 1:
  - two attempts, separated by one read=0 cycle;
  - then done with timeout=1, pass=0, id_ok=0, ts_ok=0, avm_read=0;
  - id_value holds the captured ID.
- start pulsed during RD_TS and again in the FIN cycle: both ignored; exactly one done.
- reset asserted during a stalled RD_ID: avm_read=0 and busy=0 immediately; no done. A subsequent start completes normally.
